// File: rtl/svc_fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serializes each word as a UART
// frame: one start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
module svc_fifo_uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_inc,
  output logic                 txd,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                 state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [BAUD_W-1:0]      baud_d;
  logic [BIT_W-1:0]       bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   txd_q;

  logic                   baud_end;
  logic                   stop_last;
  logic                   pop;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign stop_last = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);

  // Popping on the final stop cycle lets the next start bit follow with no idle gap.
  assign pop = rst_n && !fifo_empty && ((state_q == IDLE) || stop_last);

  always_comb begin
    baud_d = baud_q + 1'b1;
    if ((state_q == IDLE) || baud_end) begin
      baud_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      baud_q <= baud_d;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            shift_q <= fifo_data;
            bit_q   <= '0;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_q == DATA_LAST) begin
              state_q <= STOP;
              bit_q   <= '0;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (pop) begin
                state_q <= START;
                shift_q <= fifo_data;
                txd_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_inc = pop;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_svc_fifo_uart_tx.sv
// Directed bench: two instances (one and two stop bits, 4 clocks per bit)
// each fed by a simple FWFT FIFO model; outputs sampled on the falling edge.
module tb_svc_fifo_uart_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] mem1 [0:63];
  logic [7:0] mem2 [0:63];
  int wrPtr1 = 0;
  int rdPtr1 = 0;
  int wrPtr2 = 0;
  int rdPtr2 = 0;
  int popCount1 = 0;
  int popCount2 = 0;
  int illegalPops = 0;

  logic       fifoEmpty1, fifoEmpty2;
  logic [7:0] fifoData1, fifoData2;
  logic       fifoInc1, fifoInc2;
  logic       txd1, txd2;
  logic       busy1, busy2;

  assign fifoEmpty1 = (wrPtr1 == rdPtr1);
  assign fifoEmpty2 = (wrPtr2 == rdPtr2);
  assign fifoData1  = mem1[rdPtr1[5:0]];
  assign fifoData2  = mem2[rdPtr2[5:0]];

  svc_fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifoEmpty1),
    .fifo_data (fifoData1),
    .fifo_inc  (fifoInc1),
    .txd       (txd1),
    .busy      (busy1)
  );

  svc_fifo_uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifoEmpty2),
    .fifo_data (fifoData2),
    .fifo_inc  (fifoInc2),
    .txd       (txd2),
    .busy      (busy2)
  );

  // FIFO read side: advance on each pop and flag pops from an empty FIFO.
  always @(posedge clk) begin
    if (fifoInc1 === 1'b1) begin
      if (fifoEmpty1) illegalPops <= illegalPops + 1;
      else begin
        rdPtr1    <= rdPtr1 + 1;
        popCount1 <= popCount1 + 1;
      end
    end
    if (fifoInc2 === 1'b1) begin
      if (fifoEmpty2) illegalPops <= illegalPops + 1;
      else begin
        rdPtr2    <= rdPtr2 + 1;
        popCount2 <= popCount2 + 1;
      end
    end
  end

  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] value);
    if (which == 1) begin
      mem1[wrPtr1[5:0]] = value;
      wrPtr1++;
    end else begin
      mem2[wrPtr2[5:0]] = value;
      wrPtr2++;
    end
  endtask

  // Called on the falling edge of the pop cycle T0; follows one frame on dut1.
  task automatic checkFrame(input string tag, input logic [7:0] value);
    logic [9:0] expBits;
    int popStart;
    expBits  = {1'b1, value, 1'b0};
    popStart = popCount1;
    #1;
    checkOutput({tag, "_pop"}, fifoInc1, 1);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if ((k % C) == 2) checkOutput($sformatf("%s_bit%0d", tag, (k - 2) / C), txd1, expBits[(k - 2) / C]);
      if (k == 1 || k == 40) checkOutput($sformatf("%s_busy%0d", tag, k), busy1, 1);
    end
    checkOutput({tag, "_endBusy"}, busy1, 0);
    checkOutput({tag, "_endTxd"}, txd1, 1);
    checkOutput({tag, "_endInc"}, fifoInc1, 0);
    checkOutput({tag, "_pops"}, popCount1 - popStart, 1);
  endtask

  int popStart;
  int busyDrops;
  int idleBad;
  int stopHigh;
  logic [7:0] decoded [0:16];
  logic [8:0] expBits2;

  initial begin
    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_txd", txd1, 1);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_inc", fifoInc1, 0);
    checkOutput("rst_txd2", txd2, 1);
    checkOutput("rst_busy2", busy2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_txd", txd1, 1);
    checkOutput("rel_busy", busy1, 0);

    $display("[TB] single word 0xA5");
    applyStimulus(1, 8'hA5);
    checkFrame("t1", 8'hA5);

    $display("[TB] back-to-back 0x00, 0xFF");
    repeat (2) @(negedge clk);
    applyStimulus(1, 8'h00);
    applyStimulus(1, 8'hFF);
    popStart  = popCount1;
    busyDrops = 0;
    #1;
    checkOutput("t2_pop1", fifoInc1, 1);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      if (k <= 80 && busy1 !== 1'b1) busyDrops++;
      if (k == 1)  checkOutput("t2_notEmpty", fifoEmpty1, 0);
      if (k == 6)  checkOutput("t2_f1_d0", txd1, 0);
      if (k == 39) checkOutput("t2_noEarlyPop", fifoInc1, 0);
      if (k == 40) begin
        checkOutput("t2_pop2", fifoInc1, 1);
        checkOutput("t2_stop1", txd1, 1);
      end
      if (k == 41) checkOutput("t2_start2", txd1, 0);
      if (k == 46) checkOutput("t2_f2_d0", txd1, 1);
      if (k == 78) checkOutput("t2_stop2", txd1, 1);
      if (k == 81) begin
        checkOutput("t2_endBusy", busy1, 0);
        checkOutput("t2_empty", fifoEmpty1, 1);
      end
    end
    checkOutput("t2_busyDrops", busyDrops, 0);
    checkOutput("t2_pops", popCount1 - popStart, 2);

    $display("[TB] idle with empty FIFO");
    idleBad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || fifoInc1 !== 1'b0) idleBad++;
    end
    checkOutput("t3_idleBad", idleBad, 0);

    $display("[TB] reset mid-frame of 0x3C");
    popStart = popCount1;
    applyStimulus(1, 8'h3C);
    #1;
    checkOutput("t4_pop", fifoInc1, 1);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 10) checkOutput("t4_d1", txd1, 0);
      if (k == 14) checkOutput("t4_d2", txd1, 1);
      if (k == 18) begin
        checkOutput("t4_d3", txd1, 1);
        rst_n = 1'b0;
      end
      if (k == 19) begin
        checkOutput("t4_rstTxd", txd1, 1);
        checkOutput("t4_rstBusy", busy1, 0);
        checkOutput("t4_rstInc", fifoInc1, 0);
        rst_n = 1'b1;
      end
    end
    idleBad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || fifoInc1 !== 1'b0) idleBad++;
    end
    checkOutput("t4_idleBad", idleBad, 0);
    checkOutput("t4_noRetx", popCount1 - popStart, 1);
    rst_n = 1'b0;
    applyStimulus(1, 8'h5A);
    #1;
    checkOutput("t4_gatedInc", fifoInc1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkFrame("t4_after", 8'h5A);

    $display("[TB] two stop bits, 0x81 then 0x7E");
    repeat (2) @(negedge clk);
    applyStimulus(2, 8'h81);
    applyStimulus(2, 8'h7E);
    popStart = popCount2;
    stopHigh = 0;
    expBits2 = {8'h81, 1'b0};
    #1;
    checkOutput("t5_pop1", fifoInc2, 1);
    for (int k = 1; k <= 89; k++) begin
      @(negedge clk);
      if (k <= 34 && (k % C) == 2) checkOutput($sformatf("t5_bit%0d", (k - 2) / C), txd2, expBits2[(k - 2) / C]);
      if (k >= 37 && k <= 44 && txd2 === 1'b1) stopHigh++;
      if (k == 36) checkOutput("t5_lastData", txd2, 1);
      if (k == 43) checkOutput("t5_noEarlyPop", fifoInc2, 0);
      if (k == 44) checkOutput("t5_pop2", fifoInc2, 1);
      if (k == 45) checkOutput("t5_start2", txd2, 0);
      if (k == 50) checkOutput("t5_f2_d0", txd2, 0);
      if (k == 54) checkOutput("t5_f2_d1", txd2, 1);
      if (k == 88) checkOutput("t5_busyLast", busy2, 1);
      if (k == 89) checkOutput("t5_endBusy", busy2, 0);
    end
    checkOutput("t5_stopHigh", stopHigh, 8);
    checkOutput("t5_pops", popCount2 - popStart, 2);

    $display("[TB] FIFO stress 0..16");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i));
    popStart  = popCount1;
    busyDrops = 0;
    #1;
    checkOutput("t6_pop1", fifoInc1, 1);
    for (int k = 1; k <= 681; k++) begin
      int f;
      int r;
      @(negedge clk);
      f = (k - 1) / 40;
      r = (k - 1) % 40 + 1;
      if (k <= 680 && busy1 !== 1'b1) busyDrops++;
      if ((r % C) == 2 && r >= 6 && r <= 34) decoded[f][(r - 2) / C - 1] = txd1;
      if (k == 20) applyStimulus(1, 8'd16);
    end
    for (int f = 0; f < 17; f++) checkOutput($sformatf("t6_frame%0d", f), decoded[f], f);
    checkOutput("t6_busyDrops", busyDrops, 0);
    checkOutput("t6_pops", popCount1 - popStart, 17);
    checkOutput("t6_endBusy", busy1, 0);
    checkOutput("t6_empty", fifoEmpty1, 1);
    checkOutput("illegalPops", illegalPops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/svc_fifo_uart_tx.md
Name: svc_fifo_uart_tx

Overview:
- Drain stage placed directly downstream of a FWFT synchronous FIFO.
- Pops one word at a time through the FIFO read interface (empty, data, inc).
- Serializes each word as an 8N1-style UART frame on txd: start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits.
- Sends back-to-back frames with no idle gap while the FIFO stays non-empty.

Parameters:
- DATA_BITS, 8: data bits per frame; must equal the upstream FIFO DATA_WIDTH; legal range 5..9.
- CLKS_PER_BIT, 16: clk cycles per bit period; must be >= 2.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- fifo_empty  input  1  upstream FIFO r_empty.
- fifo_data  input  DATA_BITS  upstream FIFO r_data; valid whenever fifo_empty is low (FWFT).
- fifo_inc  output  1  upstream FIFO r_inc; pop strobe.
- txd  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, txd=1, baud and bit counters cleared.
  - busy=0; fifo_inc=0, gated by rst_n.
- States: IDLE, START, DATA, STOP.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 within each bit period, then wraps to 0.
- Bit counter: width $clog2(DATA_BITS+1). Counts data bits sent in DATA and stop bits sent in STOP.
- Pop rule: fifo_inc = rst_n && !fifo_empty && (state==IDLE || stop_last). Here stop_last means the final clk cycle of the final stop bit.
  - fifo_inc is combinational from state and fifo_empty.
  - fifo_inc is asserted for exactly one cycle per word.
  - fifo_inc is never asserted when fifo_empty=1.
- On a pop cycle T0:
  - fifo_data is latched into the shift register.
  - state goes to START; baud counter goes to 0.
- Output timing relative to T0 (C = CLKS_PER_BIT):
  - txd=0 for cycles T0+1..T0+C (start bit).
  - Data bit i is driven in cycles T0+1+C*(1+i) .. T0+C*(2+i).
  - Stop bit(s): txd=1 for STOP_BITS*C cycles.
  - Frame length F = (1+DATA_BITS+STOP_BITS)*C cycles.
- DATA state: shift register shifts right at the end of each bit period; txd takes the LSB. Advance to STOP after DATA_BITS periods.
- End of STOP:
  - If fifo_empty=0 at stop_last, pop immediately and go to START. The next start bit begins at T0+F+1, so no idle cycles between frames.
  - Otherwise go to IDLE with txd=1.
- busy=1 from T0+1 through the last stop cycle. It stays 1 continuously across back-to-back frames.
- The word is held in the internal shift register after the pop. fifo_data changing mid-frame has no effect on the frame in progress.
- fifo_empty rising mid-frame has no effect on the current frame.
- Reset mid-frame: frame aborts, txd=1 on the next cycle, state=IDLE. The popped word is discarded and not retransmitted.
- Upstream FIFO full/empty wrap-around needs no handling here; the FIFO owns its pointers.

Test Plan:
1. Single word, C=4, DATA_BITS=8, STOP_BITS=1, push 0xA5 into the empty FIFO.
   - Exactly one fifo_inc pulse.
   - txd sampled mid-bit = 0,1,0,1,0,0,1,0,1,1.
   - Frame is 40 cycles; busy falls at cycle 41; then txd=1 and fifo_inc=0.
2. Back-to-back, push 0x00 then 0xFF before the first pop.
   - Second fifo_inc coincides with the last stop cycle of frame 1.
   - Second start bit begins exactly 40 cycles after the first.
   - busy never drops between the frames; FIFO empty after 2 pops.
3. Idle with an empty FIFO for 100 cycles.
   - txd=1, busy=0, and fifo_inc=0 every cycle.
4. Reset mid-frame: deassert rst_n for 1 cycle at data bit 3 of 0x3C.
   - Next cycle: txd=1, busy=0.
   - With the FIFO empty, no further fifo_inc; a word pushed afterwards transmits correctly.
5. STOP_BITS=2, C=4, push 0x81.
   - Frame is 44 cycles; txd high for 8 cycles after the data.
   - Next pop occurs in the last of those 8 cycles.
6. FIFO stress: fill a depth-16 FIFO with 0..15, then push one more while transmitting.
   - 17 frames decoded in order.
   - No fifo_inc while fifo_empty=1; exactly 17 pops total.
